// File: rtl/wts_pkg.sv
// Shared constants and read-tag encoding for the wave-table RAM arbiter.
package wts_pkg;
  localparam int WTS_CH_NUM = 4;
  localparam int WTS_PTR_W  = 5;
  localparam int WTS_ADDR_W = 7;

  // Tag follows a read through the RAM pipeline. Bit 2 marks a channel
  // read, and in that case bits 1:0 hold the channel number.
  typedef logic [2:0] tag_t;
  localparam tag_t TAG_NONE = 3'd0;
  localparam tag_t TAG_CPU  = 3'd1;
  localparam tag_t TAG_CH0  = 3'd4;
  localparam tag_t TAG_CH1  = 3'd5;
  localparam tag_t TAG_CH2  = 3'd6;
  localparam tag_t TAG_CH3  = 3'd7;

  function automatic tag_t ch_tag(input logic [1:0] ch);
    return {1'b1, ch};
  endfunction
endpackage

// File: rtl/wts_rr_sel.sv
// 4-way round-robin selector: search starts at the channel after last_gnt.
module wts_rr_sel
  import wts_pkg::*;
(
  input  logic [WTS_CH_NUM-1:0] req,
  input  logic [WTS_CH_NUM-1:0] last_gnt,
  output logic [WTS_CH_NUM-1:0] gnt
);
  logic [1:0] last_idx;
  logic [1:0] idx;

  // Encode the one-hot last grant into an index.
  always_comb begin
    last_idx = '0;
    for (int i = 0; i < WTS_CH_NUM; i++)
      if (last_gnt[i]) last_idx = 2'(i);
  end

  // Walk from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = WTS_CH_NUM; k >= 1; k--) begin
      idx = last_idx + 2'(k);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/wts_ram_arbiter.sv
// Wave-table RAM arbiter: CPU port vs. 4 tone-channel fetchers, one RAM
// access per clock, registered grants, 3-cycle read return with tags.
// Macro WTS_CPU_READ_EN: when defined, CPU reads access the RAM; when
// undefined, CPU reads are acked without a RAM cycle and return 8'hFF.
module wts_ram_arbiter
  import wts_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cpu_req,
  input  logic                            cpu_wr,
  input  logic [WTS_ADDR_W-1:0]           cpu_a,
  input  logic [7:0]                      cpu_d,
  output logic                            cpu_ack,
  output logic [7:0]                      cpu_q,
  output logic                            cpu_q_valid,
  input  logic [WTS_CH_NUM-1:0]           ch_req,
  input  logic [WTS_CH_NUM*WTS_PTR_W-1:0] ch_ptr,
  output logic [WTS_CH_NUM-1:0]           ch_ack,
  output logic [7:0]                      ch_sample,
  output logic [WTS_CH_NUM-1:0]           ch_valid,
  output logic                            sram_we,
  output logic [WTS_ADDR_W-1:0]           sram_a,
  output logic [7:0]                      sram_d,
  input  logic [7:0]                      sram_q
);
  logic                  cpu_req_m, ch_pend, cpu_gnt, ch_win, cpu_fake;
  logic [WTS_CH_NUM-1:0] ch_req_m, ch_gnt, last_gnt;
  logic [1:0]            gnt_ch;
  logic [WTS_PTR_W-1:0]  sel_ptr;
  logic [2:0]            starve_cnt;
  tag_t                  tag_s1, tag_s2;
  logic                  fake_s1, fake_s2;

  // A requester whose ack is showing this cycle is still holding req.
  assign cpu_req_m = cpu_req & ~cpu_ack;
  assign ch_req_m  = ch_req & ~ch_ack;
  assign ch_pend   = |ch_req_m;

`ifdef WTS_CPU_READ_EN
  assign cpu_fake = 1'b0;
`else
  // CPU reads bypass the RAM and take no slot from the channels.
  assign cpu_fake = cpu_req_m & ~cpu_wr;
`endif

  wts_rr_sel u_rr (
    .req      (ch_req_m),
    .last_gnt (last_gnt),
    .gnt      (ch_gnt)
  );

  // Priority: CPU first unless the channels have waited STARVE_LIMIT grants.
  always_comb begin
    cpu_gnt = cpu_req_m & ~cpu_fake &
              ~((starve_cnt == 3'(STARVE_LIMIT)) & ch_pend);
    ch_win  = ~cpu_gnt & ch_pend;
    gnt_ch  = '0;
    for (int i = 0; i < WTS_CH_NUM; i++)
      if (ch_gnt[i]) gnt_ch = 2'(i);
    sel_ptr = ch_ptr[gnt_ch*WTS_PTR_W +: WTS_PTR_W];
  end

  // Round-robin history and starvation counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt   <= 4'b1000;  // next search starts at ch0
      starve_cnt <= '0;
    end else begin
      if (ch_win) last_gnt <= ch_gnt;
      if (ch_win || !ch_pend) starve_cnt <= '0;
      else if (cpu_gnt)       starve_cnt <= starve_cnt + 3'd1;
    end
  end

  // Issue stage: register the granted access onto the RAM port and acks.
  always_ff @(posedge clk) begin
    if (reset) begin
      sram_we <= 1'b0;
      sram_a  <= '0;
      sram_d  <= '0;
      cpu_ack <= 1'b0;
      ch_ack  <= '0;
      tag_s1  <= TAG_NONE;
      fake_s1 <= 1'b0;
    end else begin
      sram_we <= cpu_gnt & cpu_wr;
      cpu_ack <= cpu_gnt | cpu_fake;
      ch_ack  <= ch_win ? ch_gnt : '0;
      fake_s1 <= cpu_fake;
      tag_s1  <= TAG_NONE;
      if (cpu_gnt) begin
        sram_a <= cpu_a;
        if (cpu_wr) sram_d <= cpu_d;
        else        tag_s1 <= TAG_CPU;
      end else if (ch_win) begin
        sram_a <= {gnt_ch, sel_ptr};
        tag_s1 <= ch_tag(gnt_ch);
      end
    end
  end

  // Return stage: steer registered RAM data to the tagged requester.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_s2      <= TAG_NONE;
      fake_s2     <= 1'b0;
      cpu_q       <= '0;
      cpu_q_valid <= 1'b0;
      ch_sample   <= '0;
      ch_valid    <= '0;
    end else begin
      tag_s2      <= tag_s1;
      fake_s2     <= fake_s1;
      cpu_q_valid <= 1'b0;
      ch_valid    <= '0;
      if (tag_s2 == TAG_CPU) begin
        cpu_q       <= sram_q;
        cpu_q_valid <= 1'b1;
      end else if (tag_s2[2]) begin
        ch_sample           <= sram_q;
        ch_valid[tag_s2[1:0]] <= 1'b1;
      end
      if (fake_s2) begin
        cpu_q       <= 8'hFF;
        cpu_q_valid <= 1'b1;
      end
    end
  end
endmodule
